dmem_io_responder: RTL and testbench

- Memory-side responder for the pipelined core's data port.
- Accepts the M-stage address, write-enable and write data; returns read data in the same cycle.
- Backs the port with word RAM plus a small memory-mapped I/O page.
- The I/O page holds a free-running cycle counter and a transmit FIFO that drains through a valid/ready stream to an external sink.

---
 rtl/dmem_io_pkg.sv | 30 +++
 rtl/tx_fifo.sv | 64 ++++++
 rtl/dmem_io_responder.sv | 103 ++++++++++
 tb/tb_dmem_io_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory responder.
// I/O page offsets, STATUS bit layout, decode region type and a
// helper that packs the STATUS word.
package dmem_io_pkg;

  localparam logic [7:0] CYCLE_OFF  = 8'h00;
  localparam logic [7:0] TXDATA_OFF = 8'h04;
  localparam logic [7:0] STATUS_OFF = 8'h08;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_e;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: 8] = count;
    w[ST_OVF_BIT]        = ovf;
    w[ST_FULL_BIT]       = full;
    w[ST_EMPTY_BIT]      = empty;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO for the I/O page.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head,
// count (0..DEPTH), full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
// While empty, head holds the last word popped (0 after reset).
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import dmem_io_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_last_head;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign count     = r_count;
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign head      = empty ? r_last_head : r_mem[r_rd_ptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_head <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_last_head <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_io_responder.sv
// Data-port responder: word RAM plus a 256-byte I/O page holding a
// free-running cycle counter and a TX FIFO drained by a valid/ready stream.
// Ports: clk, reset (sync, active-high), memwrite, addr, writedata,
// readdata (combinational), out_valid/out_data/out_ready (TX stream).
module dmem_io_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);
  import dmem_io_pkg::*;

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]              r_ram [RAM_WORDS];
  logic [31:0]              r_cycle;
  logic                     r_overflow;
  region_e                  w_region;
  logic [7:0]               w_off;
  logic [AW-1:0]            w_ram_idx;
  logic                     w_io_we;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_drop;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  always_comb begin
    w_region = REG_NONE;
    if (addr < RAM_BYTES)                    w_region = REG_RAM;
    else if (addr[31:8] == IO_BASE[31:8])    w_region = REG_IO;
  end

  assign w_off     = {addr[7:2], 2'b00};
  assign w_ram_idx = addr[2 +: AW];
  assign w_io_we   = memwrite && (w_region == REG_IO);
  assign w_push    = w_io_we && (w_off == TXDATA_OFF);
  assign w_pop     = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so only a push into a full,
  // non-draining FIFO is dropped.
  assign w_drop    = w_push && w_full && !w_pop;
  assign out_valid = !w_empty;

  // RAM ignores reset, including writes issued during the reset cycle.
  always_ff @(posedge clk) begin
    if (memwrite && (w_region == REG_RAM)) r_ram[w_ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_io_we && (w_off == CYCLE_OFF)) r_cycle <= writedata + 32'd1;
      else                                 r_cycle <= r_cycle + 32'd1;
      // Set has priority over the STATUS-write clear.
      if (w_drop)                                     r_overflow <= 1'b1;
      else if (w_io_we && (w_off == STATUS_OFF))      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (w_region)
      REG_RAM: readdata = r_ram[w_ram_idx];
      REG_IO: begin
        case (w_off)
          CYCLE_OFF:  readdata = r_cycle;
          STATUS_OFF: readdata = status_word(8'(w_count), r_overflow, w_full, w_empty);
          default:    readdata = '0;
        endcase
      end
      default: readdata = '0;
    endcase
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (writedata),
    .pop       (w_pop),
    .head      (out_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_dmem_io_responder.sv
module tb_dmem_io_responder;

  localparam logic [31:0] A_CYC = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX  = 32'hFFFF_FF04;
  localparam logic [31:0] A_ST  = 32'hFFFF_FF08;

  logic        clk = 1'b0;
  logic        reset, memwrite, out_ready, out_valid;
  logic [31:0] addr, writedata, readdata, out_data;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [31:0] m_ram [64];
  bit          m_known [64];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle;
  logic [31:0] m_last;
  bit          m_ovf;

  logic [31:0] rd, od;
  logic        ov;

  dmem_io_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic bit read_known(input logic [31:0] a);
    if (a < 32'd256) return m_known[a[7:2]];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = m_q.size();
    if (a < 32'd256) return m_ram[a[7:2]];
    if (!is_io(a)) return 32'd0;
    case (a[7:2])
      6'd0: return m_cycle;
      6'd2: return {16'd0, 8'(n), 5'd0, m_ovf, (n == 8), (n == 0)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input bit rdy);
    if (we && a < 32'd256) begin
      m_ram[a[7:2]]   = wd;
      m_known[a[7:2]] = 1'b1;
    end
    if (rst) begin
      m_cycle = 0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_last = 0;
    end else begin
      if (we && is_io(a) && a[7:2] == 6'd0) m_cycle = wd + 1;
      else                                  m_cycle = m_cycle + 1;
      if (rdy && m_q.size() > 0) m_last = m_q.pop_front();
      if (we && is_io(a) && a[7:2] == 6'd1) begin
        if (m_q.size() < 8) m_q.push_back(wd);
        else                m_ovf = 1'b1;
      end else if (we && is_io(a) && a[7:2] == 6'd2) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  // One clock: drive, check combinational outputs at negedge, advance model.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input bit rdy);
    reset = rst; memwrite = we; addr = a; writedata = wd; out_ready = rdy;
    @(negedge clk);
    rd = readdata; ov = out_valid; od = out_data;
    if (read_known(a)) chk("rdata", rd, model_read(a));
    chk("valid", {31'd0, ov}, {31'd0, m_q.size() != 0});
    chk("odata", od, (m_q.size() != 0) ? m_q[0] : m_last);
    @(posedge clk);
    model_step(rst, we, a, wd, rdy);
    #1;
  endtask

  logic [31:0] exp_drain [8];
  logic [31:0] got3 [3];
  int          nv;

  initial begin
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    reset = 1'b1; memwrite = 1'b0; addr = 0; writedata = 0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_cycle = 0; m_q.delete(); m_ovf = 1'b0; m_last = 0;

    // reset state
    cyc(0, 0, A_ST, 0, 0);
    chk("rst_status", rd, 32'h0000_0001);
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_odata", od, 32'd0);

    // RAM
    cyc(0, 1, 32'h10, 32'hDEADBEEF, 0);
    cyc(0, 0, 32'h10, 0, 0);   chk("ram_rd",     rd, 32'hDEADBEEF);
    cyc(0, 0, 32'h13, 0, 0);   chk("ram_rd_off", rd, 32'hDEADBEEF);
    cyc(0, 0, 32'h100, 0, 0);  chk("unmapped",   rd, 32'd0);
    // same-cycle read returns old word
    cyc(0, 1, 32'h10, 32'h1234_5678, 0); chk("ram_old", rd, 32'hDEADBEEF);
    cyc(0, 1, 32'h10, 32'hDEADBEEF, 0);

    // cycle counter
    cyc(1, 0, A_CYC, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, A_CYC, 0, 0);
      chk("cycle_seq", rd, 32'(i));
    end
    cyc(0, 1, A_CYC, 32'hFFFF_FFFE, 0);
    cyc(0, 0, A_CYC, 0, 0); chk("cycle_ld", rd, 32'hFFFF_FFFF);
    cyc(0, 0, A_CYC, 0, 0); chk("cycle_wrap", rd, 32'd0);

    // fill, overflow, clear
    for (int i = 1; i <= 8; i++) cyc(0, 1, A_TX, 32'(i), 0);
    cyc(0, 0, A_ST, 0, 0); chk("st_full", rd, 32'h0000_0802);
    cyc(0, 1, A_TX, 32'd9, 0);
    cyc(0, 0, A_ST, 0, 0); chk("st_ovf", rd, 32'h0000_0806);
    cyc(0, 1, A_ST, 0, 0);
    cyc(0, 0, A_ST, 0, 0); chk("st_clr", rd, 32'h0000_0802);
    cyc(0, 0, A_TX, 0, 0); chk("tx_rd0", rd, 32'd0);

    // push into full FIFO while popping
    cyc(0, 1, A_TX, 32'hA5, 1);
    cyc(0, 0, A_ST, 0, 0); chk("st_pushpop", rd, 32'h0000_0802);
    for (int i = 0; i < 7; i++) exp_drain[i] = 32'(i + 2);
    exp_drain[7] = 32'hA5;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, A_ST, 0, 1);
      chk("drain", od, exp_drain[i]);
    end
    cyc(0, 0, A_ST, 0, 0); chk("st_drained", rd, 32'h0000_0001);
    chk("hold_last", od, 32'hA5);

    // three words streamed out
    cyc(0, 1, A_TX, 32'h11, 0);
    cyc(0, 1, A_TX, 32'h22, 0);
    cyc(0, 1, A_TX, 32'h33, 0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, A_ST, 0, 1);
      if (ov) begin
        if (nv < 3) got3[nv] = od;
        nv++;
      end
    end
    chk("valid_cycles", 32'(nv), 32'd3);
    chk("stream0", got3[0], 32'h11);
    chk("stream1", got3[1], 32'h22);
    chk("stream2", got3[2], 32'h33);
    cyc(0, 0, A_ST, 0, 0); chk("st_empty", rd, 32'h0000_0001);

    // reset mid-operation
    for (int i = 0; i < 5; i++) cyc(0, 1, A_TX, 32'(100 + i), 0);
    cyc(0, 1, A_CYC, 32'd1233, 0);
    cyc(1, 0, A_CYC, 0, 0); chk("cyc_pre_rst", rd, 32'd1234);
    cyc(0, 0, A_CYC, 0, 0);
    chk("rst_cycle", rd, 32'd0);
    chk("rst_valid2", {31'd0, ov}, 32'd0);
    cyc(0, 0, A_ST, 0, 0); chk("rst_status2", rd, 32'h0000_0001);
    cyc(0, 0, 32'h10, 0, 0); chk("ram_kept", rd, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, wd;
      bit we, rdy, rst;
      case ($urandom_range(0, 5))
        0, 1:    a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        2:       a = {24'hFFFFFF, 6'($urandom_range(0, 4)), 2'($urandom_range(0, 3))};
        3:       a = A_TX;
        4:       a = 32'h0000_1000 + $urandom_range(0, 65535);
        default: a = A_ST;
      endcase
      wd  = $urandom;
      we  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc(rst, we, a, wd, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
